// File: rtl/csd_meas_pkg.sv
// Shared types and parameter limits for the CapSense CSD measurement channel.
package csd_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MEAS,
    ST_DONE
  } state_e;

  localparam int CNT_W_MIN = 8;
  localparam int CNT_W_MAX = 24;
  localparam int WIN_W_MIN = 8;
  localparam int WIN_W_MAX = 24;

  function automatic bit width_ok(input int w, input int lo, input int hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/csd_sat_counter.sv
// Saturating up-counter: clear has priority, increments on en_i & inc_i, and
// holds at all-ones while raising a sticky saturation flag.
module csd_sat_counter #(
  parameter int W = 16
) (
  input  logic         op_clock,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         inc_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         sat_o
);

  logic [W-1:0] count_q, count_d;
  logic         sat_q, sat_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clear_i) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (en_i && inc_i) begin
      if (&count_q) begin
        sat_d = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge op_clock) begin
    if (reset) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count_o = count_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/csd_measure_channel.sv
// CapSense CSD measurement channel: counts PRS pulses with the sensor below
// threshold over a programmable window and publishes the count with valid/ack.
module csd_measure_channel
  import csd_meas_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int WIN_W     = 16,
  parameter bit IDAC_SINK = 1'b0
) (
  input  logic             op_clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic             pulse_i,
  input  logic             cmp_in_i,
  input  logic [WIN_W-1:0] window_period_i,
  input  logic             result_ack_i,
  output logic             ioff_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] result_o,
  output logic             result_valid_o,
  output logic             overflow_o,
  output logic             overrun_o
);

  if (!width_ok(CNT_W, CNT_W_MIN, CNT_W_MAX) || !width_ok(WIN_W, WIN_W_MIN, WIN_W_MAX)) begin : g_bad_width
    $error("csd_measure_channel: CNT_W or WIN_W outside 8..24");
  end

  state_e             state_q, state_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic               pre_q, pre_d;
  logic               cmp_s_q, cmp_s_d;
  logic [CNT_W-1:0]   result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic               overflow_q, overflow_d;
  logic               overrun_q, overrun_d;

  logic [CNT_W-1:0]   raw_cnt;
  logic               raw_sat;

  // A low synchronised comparator means the sensor is below threshold: count it.
  csd_sat_counter #(.W(CNT_W)) u_raw_cnt (
    .op_clock (op_clock),
    .reset    (reset),
    .clear_i  (state_q == ST_LOAD),
    .inc_i    (~cmp_s_q),
    .en_i     ((state_q == ST_MEAS) && pulse_i),
    .count_o  (raw_cnt),
    .sat_o    (raw_sat)
  );

  always_comb begin
    state_d        = state_q;
    win_cnt_d      = win_cnt_q;
    pre_d          = pre_q;
    cmp_s_d        = cmp_s_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    overflow_d     = overflow_q;
    overrun_d      = overrun_q;

    // The comparator is only sampled on PRS strobes, in every state.
    if (pulse_i) begin
      pre_d   = cmp_in_i ^ IDAC_SINK;
      cmp_s_d = pre_q;
    end

    if (result_ack_i) begin
      if (result_valid_q) begin
        overrun_d = 1'b0;
      end
      result_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        win_cnt_d = (window_period_i == '0) ? WIN_W'(1) : window_period_i;
        state_d   = ST_MEAS;
      end
      ST_MEAS: begin
        if (pulse_i) begin
          win_cnt_d = win_cnt_q - WIN_W'(1);
          if (win_cnt_q == WIN_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Publishing a new result overrides any ack seen this cycle.
        result_d       = raw_cnt;
        overflow_d     = raw_sat;
        overrun_d      = overrun_q | (result_valid_q & ~result_ack_i);
        result_valid_d = 1'b1;
        state_d        = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge op_clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      win_cnt_q      <= '0;
      pre_q          <= 1'b0;
      cmp_s_q        <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      win_cnt_q      <= win_cnt_d;
      pre_q          <= pre_d;
      cmp_s_q        <= cmp_s_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
      overrun_q      <= overrun_d;
    end
  end

  assign ioff_o         = cmp_s_q;
  assign busy_o         = (state_q == ST_LOAD) || (state_q == ST_MEAS);
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign overflow_o     = overflow_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_csd_measure_channel.sv
// Directed bench for csd_measure_channel: three configurations (source, sink,
// 8-bit count) share one stimulus stream and are checked against expected values.
module tb_csd_measure_channel;

  logic        op_clock = 1'b0;
  logic        reset;
  logic        start_i;
  logic        pulse_i;
  logic        cmp_in_i;
  logic [15:0] window_period_i;
  logic        result_ack_i;

  logic        ioff_a, busy_a, valid_a, ovf_a, ovr_a;
  logic [15:0] result_a;
  logic        ioff_s, busy_s, valid_s, ovf_s, ovr_s;
  logic [15:0] result_s;
  logic        ioff_b, busy_b, valid_b, ovf_b, ovr_b;
  logic [7:0]  result_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 op_clock = ~op_clock;

  csd_measure_channel #(.CNT_W(16), .WIN_W(16), .IDAC_SINK(1'b0)) dut_src (
    .op_clock(op_clock), .reset(reset), .start_i(start_i), .pulse_i(pulse_i),
    .cmp_in_i(cmp_in_i), .window_period_i(window_period_i), .result_ack_i(result_ack_i),
    .ioff_o(ioff_a), .busy_o(busy_a), .result_o(result_a), .result_valid_o(valid_a),
    .overflow_o(ovf_a), .overrun_o(ovr_a)
  );

  csd_measure_channel #(.CNT_W(16), .WIN_W(16), .IDAC_SINK(1'b1)) dut_sink (
    .op_clock(op_clock), .reset(reset), .start_i(start_i), .pulse_i(pulse_i),
    .cmp_in_i(cmp_in_i), .window_period_i(window_period_i), .result_ack_i(result_ack_i),
    .ioff_o(ioff_s), .busy_o(busy_s), .result_o(result_s), .result_valid_o(valid_s),
    .overflow_o(ovf_s), .overrun_o(ovr_s)
  );

  csd_measure_channel #(.CNT_W(8), .WIN_W(16), .IDAC_SINK(1'b0)) dut_c8 (
    .op_clock(op_clock), .reset(reset), .start_i(start_i), .pulse_i(pulse_i),
    .cmp_in_i(cmp_in_i), .window_period_i(window_period_i), .result_ack_i(result_ack_i),
    .ioff_o(ioff_b), .busy_o(busy_b), .result_o(result_b), .result_valid_o(valid_b),
    .overflow_o(ovf_b), .overrun_o(ovr_b)
  );

  typedef struct {
    int unsigned win;
    logic        cmp;
    int unsigned exp_src;
    int unsigned exp_sink;
    int unsigned exp_c8;
    logic        exp_ovf_c8;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge op_clock);
    #1;
  endtask

  task automatic pulse_once(input logic c);
    cmp_in_i = c;
    pulse_i  = 1'b1;
    tick();
    pulse_i  = 1'b0;
    tick();
  endtask

  // Two strobes fill both synchroniser stages with the level used by the scan.
  task automatic prime_and_start(input int unsigned win, input logic c);
    pulse_once(c);
    pulse_once(c);
    window_period_i = 16'(win);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    check("busy_in_meas", {31'b0, busy_a}, 32'd1);
  endtask

  task automatic run_scan(input int unsigned win, input logic c);
    int unsigned n;
    n = (win == 0) ? 1 : win;
    prime_and_start(win, c);
    for (int i = 0; i < int'(n); i++) begin
      pulse_once(c);
    end
  endtask

  task automatic ack_once();
    result_ack_i = 1'b1;
    tick();
    result_ack_i = 1'b0;
  endtask

  vec_t vecs[7];
  int   model_cnt_src;
  int   model_cnt_sink;

  initial begin
    reset = 1'b1;
    start_i = 1'b0;
    pulse_i = 1'b0;
    cmp_in_i = 1'b0;
    window_period_i = '0;
    result_ack_i = 1'b0;

    vecs[0] = '{win: 10,  cmp: 1'b0, exp_src: 10,  exp_sink: 0, exp_c8: 10,  exp_ovf_c8: 1'b0};
    vecs[1] = '{win: 8,   cmp: 1'b1, exp_src: 0,   exp_sink: 8, exp_c8: 0,   exp_ovf_c8: 1'b0};
    vecs[2] = '{win: 300, cmp: 1'b0, exp_src: 300, exp_sink: 0, exp_c8: 255, exp_ovf_c8: 1'b1};
    vecs[3] = '{win: 0,   cmp: 1'b0, exp_src: 1,   exp_sink: 0, exp_c8: 1,   exp_ovf_c8: 1'b0};
    vecs[4] = '{win: 255, cmp: 1'b0, exp_src: 255, exp_sink: 0, exp_c8: 255, exp_ovf_c8: 1'b0};
    vecs[5] = '{win: 256, cmp: 1'b0, exp_src: 256, exp_sink: 0, exp_c8: 255, exp_ovf_c8: 1'b1};
    vecs[6] = '{win: 5,   cmp: 1'b1, exp_src: 0,   exp_sink: 5, exp_c8: 0,   exp_ovf_c8: 1'b0};

    tick();
    tick();
    check("rst_busy",   {31'b0, busy_a},  32'd0);
    check("rst_result", {16'b0, result_a}, 32'd0);
    check("rst_valid",  {31'b0, valid_a}, 32'd0);
    check("rst_ovf",    {31'b0, ovf_a},   32'd0);
    check("rst_ovr",    {31'b0, ovr_a},   32'd0);
    check("rst_ioff",   {31'b0, ioff_a},  32'd0);
    reset = 1'b0;

    // Table-driven scans with a constant comparator level.
    for (int v = 0; v < 7; v++) begin
      ack_once();
      check("ack_clears_valid", {31'b0, valid_a}, 32'd0);
      run_scan(vecs[v].win, vecs[v].cmp);
      tick();
      check("tbl_busy_src",    {31'b0, busy_a},  32'd0);
      check("tbl_valid_src",   {31'b0, valid_a}, 32'd1);
      check("tbl_result_src",  {16'b0, result_a}, vecs[v].exp_src);
      check("tbl_ovf_src",     {31'b0, ovf_a},   32'd0);
      check("tbl_ovr_src",     {31'b0, ovr_a},   32'd0);
      check("tbl_ioff_src",    {31'b0, ioff_a},  {31'b0, vecs[v].cmp});
      check("tbl_result_sink", {16'b0, result_s}, vecs[v].exp_sink);
      check("tbl_ioff_sink",   {31'b0, ioff_s},  {31'b0, ~vecs[v].cmp});
      check("tbl_result_c8",   {24'b0, result_b}, vecs[v].exp_c8);
      check("tbl_ovf_c8",      {31'b0, ovf_b},   {31'b0, vecs[v].exp_ovf_c8});
    end

    // Comparator toggling every strobe; expected counts from a reference model of the sync chain.
    begin
      logic m_pre_a, m_s_a, m_pre_k, m_s_k, c;
      ack_once();
      prime_and_start(20, 1'b0);
      m_pre_a = 1'b0; m_s_a = 1'b0;
      m_pre_k = 1'b1; m_s_k = 1'b1;
      model_cnt_src = 0;
      model_cnt_sink = 0;
      for (int k = 1; k <= 20; k++) begin
        c = (k % 2 == 1);
        if (!m_s_a) model_cnt_src++;
        if (!m_s_k) model_cnt_sink++;
        m_s_a = m_pre_a; m_pre_a = c;
        m_s_k = m_pre_k; m_pre_k = ~c;
        pulse_once(c);
      end
      tick();
      check("toggle_result_src",  {16'b0, result_a}, model_cnt_src);
      check("toggle_result_sink", {16'b0, result_s}, model_cnt_sink);
      check("toggle_src_11",      {16'b0, result_a}, 32'd11);
    end

    // Two scans without ack -> overrun; ack clears both flags.
    ack_once();
    run_scan(3, 1'b0);
    tick();
    check("ovr_first_result", {16'b0, result_a}, 32'd3);
    check("ovr_first_flag",   {31'b0, ovr_a},   32'd0);
    run_scan(5, 1'b0);
    tick();
    check("ovr_second_result", {16'b0, result_a}, 32'd5);
    check("ovr_set",           {31'b0, ovr_a},   32'd1);
    check("ovr_valid",         {31'b0, valid_a}, 32'd1);
    ack_once();
    check("ack_valid_clear",   {31'b0, valid_a}, 32'd0);
    check("ack_ovr_clear",     {31'b0, ovr_a},   32'd0);

    // Ack arriving in the DONE cycle while an older result is still valid.
    run_scan(2, 1'b0);
    tick();
    check("pre_done_valid", {31'b0, valid_a}, 32'd1);
    prime_and_start(2, 1'b0);
    pulse_once(1'b0);
    pulse_i = 1'b1;
    tick();
    pulse_i = 1'b0;
    result_ack_i = 1'b1;
    tick();
    result_ack_i = 1'b0;
    check("done_ack_valid",  {31'b0, valid_a}, 32'd1);
    check("done_ack_ovr",    {31'b0, ovr_a},   32'd0);
    check("done_ack_result", {16'b0, result_a}, 32'd2);
    tick();
    check("done_ack_valid_hold", {31'b0, valid_a}, 32'd1);

    // Reset mid-scan after five strobes aborts without publishing.
    prime_and_start(20, 1'b0);
    for (int i = 0; i < 5; i++) pulse_once(1'b0);
    reset = 1'b1;
    tick();
    check("mid_rst_busy",   {31'b0, busy_a},  32'd0);
    check("mid_rst_result", {16'b0, result_a}, 32'd0);
    check("mid_rst_valid",  {31'b0, valid_a}, 32'd0);
    check("mid_rst_ovf",    {31'b0, ovf_a},   32'd0);
    check("mid_rst_ovr",    {31'b0, ovr_a},   32'd0);
    check("mid_rst_ioff_s", {31'b0, ioff_s},  32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_idle",  {31'b0, busy_a},  32'd0);
    run_scan(4, 1'b0);
    tick();
    check("post_rst_result", {16'b0, result_a}, 32'd4);
    check("post_rst_valid",  {31'b0, valid_a}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
